jtframe_ba_resp: RTL and testbench
==================================

Name: jtframe_ba_resp

Overview:
- Responder end of the four-bank ROM read interface that game tops drive (ba0..3_addr, ba_rd, ba_ack/dst/dok/rdy, data_read).
- Arbitrates bank read requests, issues word reads to a fixed-latency backing memory port, and streams each burst back with the ack/dst/dok/rdy handshake.
- Used in simulation and on boards with flat memory in place of the SDRAM controller.

Parameters:
- BURST, 2, 16-bit words returned per request; 1..4.
- MEM_LAT, 2, cycles from mem_rd to valid mem_dout; 1..7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ba0_addr  in  22  bank 0 word address
- ba1_addr  in  22  bank 1 word address
- ba2_addr  in  22  bank 2 word address
- ba3_addr  in  22  bank 3 word address
- ba_rd  in  4  per-bank read request, level, held until ack
- ba_ack  out  4  one-cycle pulse: request accepted, address latched
- ba_dst  out  4  one-cycle pulse with first data word
- ba_dok  out  4  high on every cycle data_read is valid for that bank
- ba_rdy  out  4  one-cycle pulse with last data word
- data_read  out  16  returned word
- mem_addr  out  24  {bank[1:0], word address[21:0]}
- mem_rd  out  1  memory read strobe, one word per cycle
- mem_dout  in  16  memory data, valid MEM_LAT cycles after mem_rd

Behaviour:
- Reset (async, active-high):
  - all outputs 0, FSM in IDLE, RR pointer = 3 so bank 0 wins first.
  - Reset mid-burst aborts the burst; the pipeline is flushed and no dok/rdy follows.
- Only one request is in flight at a time.
- FSM IDLE:
  - If ba_rd != 0, pick a bank by round robin, starting the search at pointer+1 mod 4.
  - Latch that bank's address, update the pointer, go to ISSUE.
  - Next cycle: ba_ack[bank] = 1 for exactly one cycle.
- FSM ISSUE:
  - mem_rd = 1 for BURST consecutive cycles, starting in the ack cycle.
  - mem_addr = {bank, addr+k} for k = 0..BURST-1; the 22-bit addition wraps (0x3FFFFF+1 -> 0).
  - Then go to DRAIN.
- FSM DRAIN:
  - A MEM_LAT-deep shift register tracks valid and last.
  - data_read is registered from mem_dout, so word k appears at ack-cycle + k + MEM_LAT + 1.
  - ba_dok[bank] is high on each of those BURST cycles.
  - ba_dst[bank] pulses with word 0; ba_rdy[bank] pulses with word BURST-1.
  - If BURST == 1, dst and rdy coincide.
  - After rdy, go to IDLE.
- Latency from ba_rd rising (while IDLE) to first dok: MEM_LAT+2 cycles. Back-to-back requests have a 1-cycle IDLE gap after rdy.
- ba_rd of the bank being served is ignored from ack until rdy. If it is still high in the IDLE cycle after rdy, it is a new request.
- A ba_rd pulse that drops before it is sampled in IDLE is lost, with no response.
- A ba_addr change after ack has no effect on the current burst.
- data_read holds its last value when dok is 0. dok/dst/rdy/ack are never asserted for more than one bank at once.

Optional Feature:
- JTFRAME_BA_PRIO_EN
  - Defined: fixed priority, bank 0 highest down to bank 3; the RR pointer is removed.
  - Undefined: round robin as described above.
- Timing and handshake are identical in both cases.

Decomposition:
- Shared package jtframe_ba_pkg holds:
  - FSM state enum {IDLE, ISSUE, DRAIN}
  - BANKS = 4
  - ADDR_W = 22
  - DATA_W = 16
- One natural sub-module, jtframe_ba_arb: 4-to-1 round-robin/priority arbiter. Inputs: request vector and pointer. Outputs: one-hot grant and 2-bit index. Combinational; the pointer register stays in the parent.

Test Plan:
- Defaults; ba_rd = 0001, ba0_addr = 0x000010, memory word n = n[15:0]:
  - ack[0] one cycle later.
  - mem_addr 0x000010 then 0x000011.
  - dok[0] for 2 cycles with data 0x0010, 0x0011; dst on the first word, rdy on the second.
  - First dok 4 cycles after rd.
- ba_rd = 1111 held continuously, dropping each bank's bit on its ack:
  - acks in order bank 0, 1, 2, 3.
  - mem_addr[23:22] follows 0, 1, 2, 3.
  - No overlapping dok.
- Same stimulus with JTFRAME_BA_PRIO_EN defined and bank 0 re-requesting immediately after each rdy: bank 0 is always granted; banks 1–3 starve until bank 0 stops.
- ba2_addr = 0x3FFFFF, BURST = 2: mem_addr 0x BFFFFF then 0x800000, with data returned to bank 2.
- rst asserted 1 cycle after ack, during DRAIN: all outputs 0 immediately. A subsequent ba_rd = 0100 is served normally, with no stale dok.
- Parameter sweep BURST ∈ {1, 4} × MEM_LAT ∈ {1, 7}:
  - dok count equals BURST.
  - With BURST = 1, dst and rdy are in the same cycle.
  - Latency to first dok is MEM_LAT+2.

Source files
------------

// File: rtl/jtframe_ba_pkg.sv
// Shared types and sizes for the four-bank ROM read responder.
package jtframe_ba_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int BANKS  = 4;
  localparam int BANK_W = 2;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  function automatic logic [BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] idx);
    bank_onehot      = '0;
    bank_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/jtframe_ba_arb.sv
// 4-to-1 combinational arbiter: grants the first requester found searching
// upward from i_ptr+1 (mod 4). A constant pointer of 3 gives fixed priority.
module jtframe_ba_arb
  import jtframe_ba_pkg::*;
(
  input  logic [BANKS-1:0]  i_req,
  input  logic [BANK_W-1:0] i_ptr,
  output logic [BANKS-1:0]  o_gnt,
  output logic [BANK_W-1:0] o_idx,
  output logic              o_vld
);

  logic [BANK_W-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int i = 1; i <= BANKS; i++) begin
      w_cand = i_ptr + BANK_W'(i);
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_ba_resp.sv
// Four-bank ROM read responder over a fixed-latency flat memory port.
// Define JTFRAME_BA_PRIO_EN for fixed bank priority (0 highest) instead of round robin.
module jtframe_ba_resp
  import jtframe_ba_pkg::*;
#(
  parameter int BURST   = 2,
  parameter int MEM_LAT = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ba0_addr,
  input  logic [ADDR_W-1:0] ba1_addr,
  input  logic [ADDR_W-1:0] ba2_addr,
  input  logic [ADDR_W-1:0] ba3_addr,
  input  logic [BANKS-1:0]  ba_rd,
  output logic [BANKS-1:0]  ba_ack,
  output logic [BANKS-1:0]  ba_dst,
  output logic [BANKS-1:0]  ba_dok,
  output logic [BANKS-1:0]  ba_rdy,
  output logic [DATA_W-1:0] data_read,
  output logic [ADDR_W+1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              r_state, w_next;
  logic [BANK_W-1:0]   w_ptr, w_idx, r_bank;
  logic [BANKS-1:0]    w_req, w_gnt;
  logic                w_gnt_vld, w_last_word, w_out_vld;
  logic [ADDR_W-1:0]   w_sel_addr, w_addr_nxt, r_addr;
  logic [1:0]          r_cnt;
  logic [MEM_LAT-1:0]  r_vld_sr, r_last_sr;
  logic [BANKS-1:0]    r_ack, r_dst, r_dok, r_rdy;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W+1:0]   r_mem_addr;
  logic                r_mem_rd;

`ifdef JTFRAME_BA_PRIO_EN
  assign w_ptr = BANK_W'(BANKS-1);
`else
  logic [BANK_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ptr <= BANK_W'(BANKS-1);
    else if (w_gnt_vld) r_ptr <= w_idx;
  end

  assign w_ptr = r_ptr;
`endif

  // requests are only looked at while idle, so the bank in service is ignored
  assign w_req = (r_state == IDLE) ? ba_rd : '0;

  jtframe_ba_arb u_arb (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_gnt_vld)
  );

  always_comb begin
    w_sel_addr = ba0_addr;
    case (w_idx)
      2'd1:    w_sel_addr = ba1_addr;
      2'd2:    w_sel_addr = ba2_addr;
      2'd3:    w_sel_addr = ba3_addr;
      default: w_sel_addr = ba0_addr;
    endcase
  end

  assign w_last_word = (r_cnt == 2'(BURST-1));
  assign w_addr_nxt  = r_addr + ADDR_W'(r_cnt) + ADDR_W'(1);
  assign w_out_vld   = r_vld_sr[MEM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld)   w_next = ISSUE;
      ISSUE:   if (w_last_word) w_next = DRAIN;
      DRAIN:   if (|r_rdy)      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank     <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_vld_sr   <= '0;
      r_last_sr  <= '0;
      r_ack      <= '0;
      r_dst      <= '0;
      r_dok      <= '0;
      r_rdy      <= '0;
      r_data     <= '0;
    end else begin
      r_ack <= w_gnt;
      if (w_gnt_vld) begin
        r_bank     <= w_idx;
        r_addr     <= w_sel_addr;
        r_cnt      <= '0;
        r_mem_rd   <= 1'b1;
        r_mem_addr <= {w_idx, w_sel_addr};
      end else if (r_state == ISSUE) begin
        if (w_last_word) begin
          r_mem_rd <= 1'b0;
        end else begin
          r_cnt      <= r_cnt + 2'd1;
          r_mem_addr <= {r_bank, w_addr_nxt};
        end
      end

      // read-tracking pipe, aligned so its tail coincides with valid mem_dout
      r_vld_sr[0]  <= r_mem_rd;
      r_last_sr[0] <= r_mem_rd & w_last_word;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end

      // words of a burst are contiguous, so the first is the one with no dok before it
      r_dok <= w_out_vld ? bank_onehot(r_bank) : '0;
      r_dst <= (w_out_vld && r_dok == '0) ? bank_onehot(r_bank) : '0;
      r_rdy <= (w_out_vld && r_last_sr[MEM_LAT-1]) ? bank_onehot(r_bank) : '0;
      if (w_out_vld) r_data <= mem_dout;
    end
  end

  assign ba_ack    = r_ack;
  assign ba_dst    = r_dst;
  assign ba_dok    = r_dok;
  assign ba_rdy    = r_rdy;
  assign data_read = r_data;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;

endmodule

// File: tb/tb_jtframe_ba_resp.sv
// Directed bench for jtframe_ba_resp: table of single-bank transactions,
// arbitration order, reset during a burst, and a BURST x MEM_LAT sweep.
module tb_jtframe_ba_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // main instance, default parameters
  logic [21:0] ba_addr [4];
  logic [3:0]  ba_rd = '0;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [15:0] m_pipe [2];

  jtframe_ba_resp u_dut (
    .clk(clk), .rst(rst),
    .ba0_addr(ba_addr[0]), .ba1_addr(ba_addr[1]),
    .ba2_addr(ba_addr[2]), .ba3_addr(ba_addr[3]),
    .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .data_read(data_read), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(m_pipe[1])
  );

  // memory: word n holds n[15:0], readable 2 cycles after mem_rd
  always @(posedge clk) begin
    m_pipe[0] <= mem_rd ? mem_addr[15:0] : 16'hDEAD;
    m_pipe[1] <= m_pipe[0];
  end

  // sweep instances: k=0 (1,1) k=1 (1,7) k=2 (4,1) k=3 (4,7)
  logic        sw_clr = 1'b1;
  logic [3:0]  sw_rd = '0;
  logic [21:0] sw_addr = 22'h000100;
  logic [3:0]  sw_ack [4], sw_dst [4], sw_dok [4], sw_rdy [4];
  logic [15:0] sw_data [4];
  logic [23:0] sw_maddr [4];
  logic        sw_mrd [4];
  int          sw_cnt [4], sw_first [4], sw_dstc [4], sw_rdyc [4];
  logic [15:0] sw_last [4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int B = (k >= 2) ? 4 : 1;
    localparam int L = (k % 2 == 1) ? 7 : 1;
    logic [15:0] pipe [L];
    jtframe_ba_resp #(.BURST(B), .MEM_LAT(L)) u_sw (
      .clk(clk), .rst(rst),
      .ba0_addr(sw_addr), .ba1_addr(22'd0), .ba2_addr(22'd0), .ba3_addr(22'd0),
      .ba_rd(sw_rd), .ba_ack(sw_ack[k]), .ba_dst(sw_dst[k]), .ba_dok(sw_dok[k]),
      .ba_rdy(sw_rdy[k]), .data_read(sw_data[k]), .mem_addr(sw_maddr[k]),
      .mem_rd(sw_mrd[k]), .mem_dout(pipe[L-1])
    );
    always @(posedge clk) begin
      pipe[0] <= sw_mrd[k] ? sw_maddr[k][15:0] : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sw_clr) begin
        sw_cnt[k] = 0; sw_first[k] = 0; sw_dstc[k] = -1; sw_rdyc[k] = -1; sw_last[k] = '0;
      end else begin
        if (sw_dok[k][0]) begin
          if (sw_cnt[k] == 0) sw_first[k] = cyc;
          sw_cnt[k]++;
          sw_last[k] = sw_data[k];
        end
        if (sw_dst[k][0]) sw_dstc[k] = cyc;
        if (sw_rdy[k][0]) sw_rdyc[k] = cyc;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ack"},  32'(ba_ack), 0);
    check({nm, "_dst"},  32'(ba_dst), 0);
    check({nm, "_dok"},  32'(ba_dok), 0);
    check({nm, "_rdy"},  32'(ba_rdy), 0);
    check({nm, "_data"}, 32'(data_read), 0);
    check({nm, "_maddr"}, 32'(mem_addr), 0);
    check({nm, "_mrd"},  32'(mem_rd), 0);
  endtask

  // one request on one bank; drops ba_rd and scrambles the address on ack
  task automatic do_req(input string nm, input int bank, input logic [21:0] addr,
                        input logic [23:0] a0, input logic [23:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1);
    int t0 = 0, nack = 0, ack_c = 0, nrd = 0, ndok = 0, first = 0;
    int dst_i = -1, dst_n = 0, rdy_i = -1, rdy_n = 0;
    logic [3:0]  ack_v = '0, dok_v = '0;
    logic [23:0] ma [4];
    logic [15:0] dd [4];
    for (int i = 0; i < 4; i++) begin ma[i] = '0; dd[i] = '0; end
    @(negedge clk);
    ba_addr[bank] = addr;
    ba_rd = 4'(1 << bank);
    t0 = cyc;
    repeat (20) begin
      @(negedge clk);
      if (ba_ack != '0) begin
        if (nack == 0) begin ack_v = ba_ack; ack_c = cyc; end
        nack++;
        ba_rd = '0;
        ba_addr[bank] = ~addr;
      end
      if (mem_rd) begin
        if (nrd < 4) ma[nrd] = mem_addr;
        nrd++;
      end
      if (ba_dok != '0) begin
        if (ndok == 0) begin first = cyc; dok_v = ba_dok; end
        if (ndok < 4) dd[ndok] = data_read;
        if (ba_dst != '0) begin dst_i = ndok; dst_n++; end
        if (ba_rdy != '0) begin rdy_i = ndok; rdy_n++; end
        ndok++;
      end else begin
        if (ba_dst != '0) dst_n++;
        if (ba_rdy != '0) rdy_n++;
      end
    end
    check({nm, "_ack_val"}, 32'(ack_v), 32'(1 << bank));
    check({nm, "_ack_lat"}, ack_c - t0, 1);
    check({nm, "_ack_cnt"}, nack, 1);
    check({nm, "_rd_cnt"}, nrd, 2);
    check({nm, "_maddr0"}, 32'(ma[0]), 32'(a0));
    check({nm, "_maddr1"}, 32'(ma[1]), 32'(a1));
    check({nm, "_dok_cnt"}, ndok, 2);
    check({nm, "_dok_bank"}, 32'(dok_v), 32'(1 << bank));
    check({nm, "_dok_lat"}, first - t0, 4);
    check({nm, "_data0"}, 32'(dd[0]), 32'(d0));
    check({nm, "_data1"}, 32'(dd[1]), 32'(d1));
    check({nm, "_dst_idx"}, dst_i, 0);
    check({nm, "_dst_cnt"}, dst_n, 1);
    check({nm, "_rdy_idx"}, rdy_i, 1);
    check({nm, "_rdy_cnt"}, rdy_n, 1);
    check({nm, "_hold"}, 32'(data_read), 32'(d1));
  endtask

  typedef struct {
    int          bank;
    logic [21:0] addr;
    logic [23:0] a0, a1;
    logic [15:0] d0, d1;
  } vec_t;

  vec_t vt [4];
  int   exp_ord [6];

  initial begin
    int nacks, b0, ovl, got, stale, t0, b, l;
    logic [1:0] idx;

    vt[0] = '{0, 22'h000010, 24'h000010, 24'h000011, 16'h0010, 16'h0011};
    vt[1] = '{2, 22'h3FFFFF, 24'hBFFFFF, 24'h800000, 16'hFFFF, 16'h0000};
    vt[2] = '{1, 22'h12345A, 24'h52345A, 24'h52345B, 16'h345A, 16'h345B};
    vt[3] = '{3, 22'h0ABCDE, 24'hCABCDE, 24'hCABCDF, 16'hBCDE, 16'hBCDF};
`ifdef JTFRAME_BA_PRIO_EN
    exp_ord = '{0, 0, 0, 1, 2, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0, 0};
`endif
    for (int i = 0; i < 4; i++) ba_addr[i] = '0;

    #1 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      do_req($sformatf("vec%0d", i), vt[i].bank, vt[i].addr, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);

    // all four banks requesting; bank 0 keeps asking until its third grant
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ba_rd = 4'hF; nacks = 0; b0 = 0; ovl = 0; idx = '0;
    for (int c = 0; c < 120 && nacks < 6; c++) begin
      @(negedge clk);
      if (!$onehot0(ba_dok) || !$onehot0(ba_ack)) ovl++;
      if (ba_ack != '0) begin
        for (int k = 0; k < 4; k++) if (ba_ack[k]) idx = 2'(k);
        check($sformatf("arb_order%0d", nacks), 32'(idx), exp_ord[nacks]);
        check($sformatf("arb_mbank%0d", nacks), {29'd0, mem_rd, mem_addr[23:22]}, {29'd0, 1'b1, 2'(exp_ord[nacks])});
        if (idx == 2'd0) begin
          b0++;
          if (b0 == 3) ba_rd[0] = 1'b0;
        end else begin
          ba_rd[idx] = 1'b0;
        end
        nacks++;
      end
    end
    check("arb_ack_total", nacks, 6);
    repeat (12) begin
      @(negedge clk);
      if (!$onehot0(ba_dok)) ovl++;
    end
    check("arb_no_overlap", ovl, 0);

    // reset while the burst is draining
    @(negedge clk);
    ba_addr[1] = 22'h000040; ba_rd = 4'b0010; got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (ba_ack[1]) got = 1;
    end
    check("midrst_ack", got, 1);
    ba_rd = '0;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk); rst = 1'b0;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (ba_dok != '0 || ba_rdy != '0 || ba_dst != '0) stale++;
    end
    check("midrst_no_stale", stale, 0);
    do_req("post_rst", 2, 22'h000020, 24'h800020, 24'h800021, 16'h0020, 16'h0021);

    // parameter sweep
    @(negedge clk);
    sw_clr = 1'b0; sw_rd = 4'b0001; t0 = cyc;
    @(negedge clk);
    sw_rd = '0;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      b = (k >= 2) ? 4 : 1;
      l = (k % 2 == 1) ? 7 : 1;
      check($sformatf("sw%0d_dok_cnt", k), sw_cnt[k], b);
      check($sformatf("sw%0d_lat", k), sw_first[k] - t0, l + 2);
      check($sformatf("sw%0d_dst_first", k), sw_dstc[k], sw_first[k]);
      check($sformatf("sw%0d_rdy_span", k), sw_rdyc[k] - sw_dstc[k], b - 1);
      check($sformatf("sw%0d_last", k), 32'(sw_last[k]), 32'h0100 + 32'(b - 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
